// File: rtl/fifo_nibble_packer.sv
// Read-side nibble packer: drains a 4-bit FIFO under credit control and emits bytes.
// Define PACKER_MSB_FIRST_EN to place the first nibble of a pair in OutData[7:4].
module fifo_nibble_packer #(
    parameter int NIB_DEPTH   = 4,
    parameter int CNT_W       = 16,
    parameter int FIFO_RD_LAT = 1
) (
    input  logic             RdClock,
    input  logic             Reset,
    input  logic [3:0]       FifoQ,
    input  logic             FifoEmpty,
    output logic             FifoRdEn,
    output logic [7:0]       OutData,
    output logic             OutValid,
    input  logic             OutReady,
    input  logic             Flush,
    output logic [CNT_W-1:0] ByteCount,
    output logic             Busy
);

    localparam int AW = $clog2(NIB_DEPTH);
    localparam int SW = AW + 2;

    typedef enum logic {S_LO, S_HI} state_e;

    logic [FIFO_RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [AW:0]            wr_ptr_q, rd_ptr_q;
    logic [3:0]             nib_mem_q [NIB_DEPTH];
    state_e                 state_q, state_d;
    logic [3:0]             lo_q, lo_d;
    logic [7:0]             out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic [CNT_W-1:0]       cnt_q;

    logic [AW:0]   occ;
    logic [SW-1:0] inflight, credit;
    logic          rd_en, push, pop;
    logic          buf_empty, buf_full, out_free, accept;
    logic [3:0]    pop_nib;
    logic [7:0]    pair_byte;

    assign occ       = wr_ptr_q - rd_ptr_q;
    assign buf_empty = (occ == '0);
    assign buf_full  = (occ == (AW+1)'(NIB_DEPTH));
    assign pop_nib   = nib_mem_q[rd_ptr_q[AW-1:0]];
    assign push      = rd_pipe_q[FIFO_RD_LAT-1];
    assign out_free  = !out_valid_q || OutReady;
    assign accept    = out_valid_q && OutReady;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < FIFO_RD_LAT; i++) begin
            inflight = inflight + SW'(rd_pipe_q[i]);
        end
    end

    // Reads in flight hold a buffer slot so a returning nibble always fits.
    assign credit = SW'(occ) + inflight;
    assign rd_en  = !FifoEmpty && !Reset && (credit < SW'(NIB_DEPTH));

    always_comb begin
        rd_pipe_d[0] = rd_en;
        for (int i = 1; i < FIFO_RD_LAT; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

`ifdef PACKER_MSB_FIRST_EN
    assign pair_byte = {lo_q, pop_nib};
`else
    assign pair_byte = {pop_nib, lo_q};
`endif

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !OutReady;
        pop         = 1'b0;
        unique case (state_q)
            S_LO: begin
                if (!buf_empty) begin
                    pop     = 1'b1;
                    lo_d    = pop_nib;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (!buf_empty && out_free) begin
                    pop = 1'b1;
                    // A flush on the completion pop restarts the pair with this nibble.
                    if (Flush) begin
                        lo_d = pop_nib;
                    end else begin
                        out_data_d  = pair_byte;
                        out_valid_d = 1'b1;
                        state_d     = S_LO;
                    end
                end else if (Flush) begin
                    state_d = S_LO;
                end
            end
            default: state_d = S_LO;
        endcase
    end

    always_ff @(posedge RdClock or posedge Reset) begin
        if (Reset) begin
            rd_pipe_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_LO;
            lo_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rd_pipe_q   <= rd_pipe_d;
            state_q     <= state_d;
            lo_q        <= lo_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (accept) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge RdClock) begin
        if (push) nib_mem_q[wr_ptr_q[AW-1:0]] <= FifoQ;
    end

    assign FifoRdEn  = rd_en;
    assign OutData   = out_data_q;
    assign OutValid  = out_valid_q;
    assign ByteCount = cnt_q;
    assign Busy      = !buf_empty || (|rd_pipe_q) || out_valid_q;

`ifndef SYNTHESIS
    always @(posedge RdClock) begin
        if (!Reset) begin
            assert (!(push && buf_full)) else $error("nibble buffer overflow");
            assert (!(pop && buf_empty)) else $error("nibble buffer underflow");
        end
    end
`endif

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Scoreboard bench for fifo_nibble_packer with a 2-cycle-latency FIFO model.
// Honours PACKER_MSB_FIRST_EN for expected byte layout.
module tb_fifo_nibble_packer;

    logic       RdClock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] FifoQ = '0;
    logic       FifoEmpty = 1'b1;
    logic       FifoRdEn;
    logic [7:0] OutData;
    logic       OutValid;
    logic       OutReady = 1'b0;
    logic       Flush = 1'b0;
    logic [3:0] ByteCount;
    logic       Busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0;
    logic [1:0] rd_hist = '0;

    logic [3:0] src[$];
    logic [7:0] exp_q[$];
    int         acc_cyc[$];
    logic [3:0] lo_n;
    logic       have_lo = 1'b0;
    logic [3:0] q1 = '0;
    logic       hold_v = 1'b0;
    logic [7:0] held = '0;

    fifo_nibble_packer #(
        .NIB_DEPTH(4),
        .CNT_W(4),
        .FIFO_RD_LAT(2)
    ) dut (
        .RdClock(RdClock),
        .Reset(Reset),
        .FifoQ(FifoQ),
        .FifoEmpty(FifoEmpty),
        .FifoRdEn(FifoRdEn),
        .OutData(OutData),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .Flush(Flush),
        .ByteCount(ByteCount),
        .Busy(Busy)
    );

    always #5 RdClock = ~RdClock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // FIFO model: data appears two cycles after the read enable.
    always @(posedge RdClock or posedge Reset) begin
        if (Reset) begin
            src.delete();
            q1        <= '0;
            FifoQ     <= '0;
            FifoEmpty <= 1'b1;
        end else begin
            if (FifoRdEn) q1 <= src.pop_front();
            FifoQ     <= q1;
            FifoEmpty <= (src.size() == 0);
        end
    end

    always @(posedge RdClock) begin
        cyc <= cyc + 1;
        rd_hist <= {rd_hist[0], FifoRdEn};
        if (!Reset && FifoRdEn) rd_cnt <= rd_cnt + 1;
    end

    always @(negedge RdClock) begin
        if (Reset) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v) check("hold", OutData, held);
            if (OutValid && OutReady) begin
                if (exp_q.size() == 0) check("spurious", OutValid, 0);
                else check("byte", OutData, exp_q.pop_front());
                acc_cyc.push_back(cyc);
            end
            hold_v <= OutValid && !OutReady;
            held   <= OutData;
        end
    end

    task automatic push_nib(input logic [3:0] n);
        src.push_back(n);
        if (have_lo) begin
`ifdef PACKER_MSB_FIRST_EN
            exp_q.push_back({lo_n, n});
`else
            exp_q.push_back({n, lo_n});
`endif
            have_lo = 1'b0;
        end else begin
            lo_n    = n;
            have_lo = 1'b1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge RdClock);
        #1;
    endtask

    task automatic do_reset();
        tick(1);
        Reset    = 1'b1;
        OutReady = 1'b0;
        Flush    = 1'b0;
        #1;
        check("rst_rden", FifoRdEn, 0);
        check("rst_valid", OutValid, 0);
        check("rst_data", OutData, 8'h00);
        check("rst_bcnt", ByteCount, 0);
        check("rst_busy", Busy, 0);
        exp_q.delete();
        acc_cyc.delete();
        have_lo = 1'b0;
        tick(2);
        Reset = 1'b0;
        tick(1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || Busy) && n < budget) begin
            tick(1);
            n++;
        end
        check("drain", exp_q.size(), 0);
        check("idle", Busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int n;
        do_reset();

        // single pair
        OutReady = 1'b1;
        push_nib(4'h3);
        push_nib(4'hA);
        drain(60);
        check("t1_bcnt", ByteCount, 1);

        // continuous stream, one byte every two cycles
        do_reset();
        OutReady = 1'b1;
        for (int i = 0; i < 32; i++) push_nib(4'(i));
        drain(200);
        check("t2_nbytes", acc_cyc.size(), 16);
        if (acc_cyc.size() == 16)
            check("t2_rate", acc_cyc[15] - acc_cyc[0], 30);
        check("t2_bcnt", ByteCount, 0);

        // backpressure
        do_reset();
        OutReady = 1'b0;
        rd_cnt   = 0;
        for (int i = 0; i < 16; i++) push_nib(4'((i * 5 + 2) % 16));
        tick(20);
        check("t3_rden", FifoRdEn, 0);
        check("t3_rds", rd_cnt, 7);
        check("t3_valid", OutValid, 1);
        check("t3_busy", Busy, 1);
        OutReady = 1'b1;
        drain(200);
        check("t3_bcnt", ByteCount, 8);

        // flush of a held low nibble
        do_reset();
        OutReady = 1'b1;
        push_nib(4'h5);
        tick(10);
        Flush = 1'b1;
        tick(1);
        Flush   = 1'b0;
        have_lo = 1'b0;
        push_nib(4'h1);
        push_nib(4'h2);
        drain(60);
        check("t4_bcnt", ByteCount, 1);

        // reset mid-stream with reads in flight
        do_reset();
        OutReady = 1'b1;
        for (int i = 0; i < 40; i++) push_nib(4'($urandom_range(0, 15)));
        n = 0;
        while (!(OutValid && rd_hist == 2'b11) && n < 100) begin
            tick(1);
            n++;
        end
        check("t5_setup", OutValid && rd_hist == 2'b11, 1);
        Reset = 1'b1;
        #1;
        check("t5_rden", FifoRdEn, 0);
        check("t5_valid", OutValid, 0);
        check("t5_data", OutData, 8'h00);
        check("t5_busy", Busy, 0);
        check("t5_bcnt", ByteCount, 0);
        exp_q.delete();
        have_lo = 1'b0;
        tick(2);
        Reset = 1'b0;
        tick(5);
        check("t5_stale", OutValid, 0);
        push_nib(4'h7);
        push_nib(4'h8);
        drain(60);
        check("t5_bcnt2", ByteCount, 1);

        // counter wrap: 17 bytes on a 4-bit counter
        do_reset();
        OutReady = 1'b1;
        for (int i = 0; i < 34; i++) push_nib(4'($urandom_range(0, 15)));
        drain(300);
        check("t6_bcnt", ByteCount, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
